// File: rtl/pb_interrupt_arbiter_if.sv
// PicoBlaze (kcpsm6) port bus plus interrupt handshake, shared between the
// processor (master) and the interrupt arbiter (slave).
interface pb_interrupt_arbiter_if;
  logic [7:0] port_id;
  logic       read_strobe;
  logic       write_strobe;
  logic [7:0] out_port;
  logic       interrupt_ack;
  logic       interrupt;
  logic [7:0] pb_in_port;

  // Processor side: drives the I/O bus and the acknowledge.
  modport master (
    output port_id, read_strobe, write_strobe, out_port, interrupt_ack,
    input  interrupt, pb_in_port
  );

  // Arbiter side: raises the interrupt and feeds in_port.
  modport slave (
    input  port_id, read_strobe, write_strobe, out_port, interrupt_ack,
    output interrupt, pb_in_port
  );
endinterface

// File: rtl/pb_interrupt_arbiter.sv
// Shares the single kcpsm6 interrupt line and in_port among N_SRC requesters.
// Each request edge captures its data byte; one source at a time is presented
// to the processor by fixed priority (index 0 highest). A DATA_PORT read ends
// the service; a service left open for TMO_CYCLES is aborted and flagged.
module pb_interrupt_arbiter #(
  parameter int         N_SRC      = 4,
  parameter logic [7:0] ID_PORT    = 8'h03,
  parameter logic [7:0] DATA_PORT  = 8'h04,
  parameter logic [7:0] STAT_PORT  = 8'h05,
  parameter logic [7:0] CLR_PORT   = 8'h06,
  parameter int         TMO_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SRC-1:0]     req,
  input  logic [8*N_SRC-1:0]   src_data,
  pb_interrupt_arbiter_if.slave pb,
  output logic                 busy,
  output logic [N_SRC-1:0]     overflow,
  output logic                 timeout
);

  localparam int TW = $clog2(TMO_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

  state_t           state_reg;
  logic             interrupt_reg;
  logic [2:0]       active_idx_reg;
  logic [TW-1:0]    timer_reg;
  logic             timeout_reg;
  logic [7:0]       pb_in_port_reg;

  logic [N_SRC-1:0] req_q_reg;
  logic [N_SRC-1:0] pending_reg;
  logic [N_SRC-1:0] overflow_reg;
  logic [7:0]       data_reg [N_SRC];

  logic [N_SRC-1:0] req_edge;
  logic [N_SRC-1:0] release_vec;
  logic [2:0]       next_idx;
  logic [7:0]       data_sel;
  logic [6:0]       stat_ovf;
  logic             data_rd;
  logic             clr_write;
  logic             service_done;
  logic             abort;
  logic             release_any;

  assign req_edge     = req & ~req_q_reg;
  assign data_rd      = pb.read_strobe && (pb.port_id == DATA_PORT);
  assign clr_write    = pb.write_strobe && (pb.port_id == CLR_PORT);
  assign service_done = (state_reg == SERVICE) && data_rd;
  // A read landing on the last timer cycle still counts as a completed service.
  assign abort        = ((state_reg == ASSERT) || (state_reg == SERVICE)) &&
                        (timer_reg == TW'(TMO_CYCLES - 1)) && !service_done;
  assign release_any  = service_done || abort;

  assign busy          = (state_reg != IDLE);
  assign overflow      = overflow_reg;
  assign timeout       = timeout_reg;
  assign pb.interrupt  = interrupt_reg;
  assign pb.pb_in_port = pb_in_port_reg;

  // Status byte only has room for seven overflow bits; pad or drop the rest.
  for (genvar gi = 0; gi < 7; gi++) begin : g_stat
    if (gi < N_SRC) begin : g_used
      assign stat_ovf[gi] = overflow_reg[gi];
    end else begin : g_pad
      assign stat_ovf[gi] = 1'b0;
    end
  end

  // Per-source release strobe, priority pick and active-data mux.
  always_comb begin
    release_vec = '0;
    next_idx    = '0;
    data_sel    = '0;
    for (int i = 0; i < N_SRC; i++) begin
      release_vec[i] = release_any && (active_idx_reg == 3'(i));
      if (active_idx_reg == 3'(i)) data_sel = data_reg[i];
    end
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pending_reg[i]) next_idx = 3'(i);
    end
  end

  // Request capture: edge sets pending and latches data; an edge on a source
  // still pending (and not being released this cycle) is lost and flagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q_reg    <= '0;
      pending_reg  <= '0;
      overflow_reg <= '0;
      for (int i = 0; i < N_SRC; i++) data_reg[i] <= 8'h00;
    end else begin
      req_q_reg <= req;
      for (int i = 0; i < N_SRC; i++) begin
        if (req_edge[i]) begin
          pending_reg[i] <= 1'b1;
          if (!pending_reg[i] || release_vec[i]) data_reg[i] <= src_data[8*i +: 8];
        end else if (release_vec[i]) begin
          pending_reg[i] <= 1'b0;
        end
        if (req_edge[i] && pending_reg[i] && !release_vec[i]) overflow_reg[i] <= 1'b1;
        else if (clr_write && pb.out_port[i]) overflow_reg[i] <= 1'b0;
      end
    end
  end

  // Service FSM: arbitrate in IDLE, hold interrupt until ack, wait for the
  // DATA_PORT read, abort on timer expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      interrupt_reg  <= 1'b0;
      active_idx_reg <= '0;
      timer_reg      <= '0;
      timeout_reg    <= 1'b0;
    end else begin
      if (abort) timeout_reg <= 1'b1;
      else if (clr_write && pb.out_port[7]) timeout_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (|pending_reg) begin
            active_idx_reg <= next_idx;
            interrupt_reg  <= 1'b1;
            timer_reg      <= '0;
            state_reg      <= ASSERT;
          end
        end
        ASSERT: begin
          timer_reg <= timer_reg + 1'b1;
          if (abort) begin
            interrupt_reg <= 1'b0;
            state_reg     <= IDLE;
          end else if (pb.interrupt_ack) begin
            interrupt_reg <= 1'b0;
            state_reg     <= SERVICE;
          end
        end
        SERVICE: begin
          timer_reg <= timer_reg + 1'b1;
          if (release_any) state_reg <= IDLE;
        end
        default: begin
          interrupt_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  // Registered in_port mux, refreshed every cycle from the current port_id.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pb_in_port_reg <= 8'h00;
    end else if (pb.port_id == ID_PORT) begin
      pb_in_port_reg <= {busy, 4'b0000, active_idx_reg};
    end else if (pb.port_id == DATA_PORT) begin
      pb_in_port_reg <= data_sel;
    end else if (pb.port_id == STAT_PORT) begin
      pb_in_port_reg <= {timeout_reg, stat_ovf};
    end else begin
      pb_in_port_reg <= 8'h00;
    end
  end

endmodule

// File: tb/tb_pb_interrupt_arbiter.sv
// Directed bench for pb_interrupt_arbiter with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pb_interrupt_arbiter;
  localparam int         N_SRC = 4;
  localparam int         TMO   = 32;
  localparam logic [7:0] ID_P  = 8'h03;
  localparam logic [7:0] DAT_P = 8'h04;
  localparam logic [7:0] STA_P = 8'h05;
  localparam logic [7:0] CLR_P = 8'h06;

  logic               clk = 1'b0;
  logic               reset;
  logic [N_SRC-1:0]   req;
  logic [8*N_SRC-1:0] src_data;
  logic               busy;
  logic [N_SRC-1:0]   overflow;
  logic               timeout;

  int checks = 0;
  int errors = 0;

  pb_interrupt_arbiter_if bus();

  pb_interrupt_arbiter #(
    .N_SRC(N_SRC), .ID_PORT(ID_P), .DATA_PORT(DAT_P), .STAT_PORT(STA_P),
    .CLR_PORT(CLR_P), .TMO_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .src_data(src_data), .pb(bus),
    .busy(busy), .overflow(overflow), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_byte(input int idx, input logic [7:0] val);
    src_data[8*idx +: 8] = val;
  endtask

  task automatic ack();
    bus.interrupt_ack = 1'b1;
    tick();
    bus.interrupt_ack = 1'b0;
  endtask

  task automatic rd(input logic [7:0] port, output logic [7:0] val);
    bus.port_id     = port;
    bus.read_strobe = 1'b1;
    tick();
    val             = bus.pb_in_port;
    bus.read_strobe = 1'b0;
    bus.port_id     = 8'h00;
  endtask

  task automatic wr(input logic [7:0] port, input logic [7:0] val);
    bus.port_id      = port;
    bus.out_port     = val;
    bus.write_strobe = 1'b1;
    tick();
    bus.write_strobe = 1'b0;
    bus.port_id      = 8'h00;
    bus.out_port     = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int cnt;
    reset = 1'b0; req = '0; src_data = '0;
    bus.port_id = 8'h00; bus.read_strobe = 1'b0; bus.write_strobe = 1'b0;
    bus.out_port = 8'h00; bus.interrupt_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_interrupt", bus.interrupt, 0);
    check("rst_in_port", bus.pb_in_port, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {timeout, overflow}, 0);
    reset = 1'b1;
    tick();

    // Single source 1: latency, ID, data, release
    req = 4'b0010; set_byte(1, 8'h1D);
    tick();
    check("t2_int_lat1", bus.interrupt, 0);
    tick();
    check("t2_int_lat2", bus.interrupt, 1);
    check("t2_busy", busy, 1);
    ack();
    check("t2_int_after_ack", bus.interrupt, 0);
    rd(ID_P, v);  check("t2_id", v, 8'h81);
    rd(DAT_P, v); check("t2_data", v, 8'h1D);
    check("t2_busy_done", busy, 0);

    // Simultaneous sources 0 and 2: priority order
    req = 4'b0000; tick();
    req = 4'b0101; set_byte(0, 8'hA0); set_byte(2, 8'hC2);
    tick(); tick();
    check("t3_int_first", bus.interrupt, 1);
    ack();
    rd(ID_P, v);  check("t3_id_first", v, 8'h80);
    rd(DAT_P, v); check("t3_data_first", v, 8'hA0);
    tick();
    check("t3_int_second", bus.interrupt, 1);
    ack();
    rd(ID_P, v);  check("t3_id_second", v, 8'h82);
    rd(DAT_P, v); check("t3_data_second", v, 8'hC2);
    check("t3_busy_done", busy, 0);

    // Double edge on source 3: overflow, data kept, clear via CLR_PORT
    req = 4'b0000; tick();
    req = 4'b1000; set_byte(3, 8'h33); tick();
    req = 4'b0000; tick();
    req = 4'b1000; set_byte(3, 8'h44); tick();
    req = 4'b0000;
    check("t4_overflow", overflow, 4'b1000);
    rd(STA_P, v); check("t4_stat", v, 8'h08);
    ack();
    rd(ID_P, v);  check("t4_id", v, 8'h83);
    rd(DAT_P, v); check("t4_data_first", v, 8'h33);
    wr(CLR_P, 8'h08);
    check("t4_overflow_clr", overflow, 0);

    // Re-trigger of source 0 in the same cycle as its DATA_PORT read
    tick();
    req = 4'b0001; set_byte(0, 8'h11); tick(); tick();
    check("t6_int", bus.interrupt, 1);
    ack();
    req = 4'b0000; tick();
    req = 4'b0001; set_byte(0, 8'h22);
    bus.port_id = DAT_P; bus.read_strobe = 1'b1;
    tick();
    bus.read_strobe = 1'b0; bus.port_id = 8'h00;
    check("t6_data_old", bus.pb_in_port, 8'h11);
    check("t6_no_overflow", overflow, 0);
    tick();
    check("t6_int_again", bus.interrupt, 1);
    ack();
    rd(DAT_P, v); check("t6_data_new", v, 8'h22);
    check("t6_busy_done", busy, 0);

    // Ack without data read: abort after TMO cycles
    req = 4'b0000; tick();
    req = 4'b0010; set_byte(1, 8'h55); tick(); tick();
    check("t5_int", bus.interrupt, 1);
    bus.interrupt_ack = 1'b1;
    tick();
    bus.interrupt_ack = 1'b0;
    cnt = 1;
    while (busy && cnt < 200) begin
      tick();
      cnt++;
    end
    check("t5_abort_cycles", cnt, TMO);
    check("t5_timeout", timeout, 1);
    rd(STA_P, v); check("t5_stat", v, 8'h80);
    tick(); tick();
    check("t5_no_reassert", bus.interrupt, 0);
    check("t5_idle", busy, 0);
    wr(CLR_P, 8'h80);
    check("t5_timeout_clr", timeout, 0);

    // Reset asserted mid-ASSERT with overflow pending
    req = 4'b0000; tick();
    req = 4'b1000; set_byte(3, 8'h77); tick();
    req = 4'b0000; tick();
    req = 4'b1000; bus.port_id = ID_P; tick();
    check("t1_pre_int", bus.interrupt, 1);
    check("t1_pre_ovf", overflow, 4'b1000);
    check("t1_pre_inport", bus.pb_in_port, 8'h83);
    reset = 1'b0;
    #1;
    check("t1_int", bus.interrupt, 0);
    check("t1_busy", busy, 0);
    check("t1_flags", {timeout, overflow}, 0);
    check("t1_inport", bus.pb_in_port, 0);
    req = 4'b0000; bus.port_id = 8'h00;
    tick();
    reset = 1'b1;
    tick(); tick();
    check("t1_post_int", bus.interrupt, 0);
    check("t1_post_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
